vga_timing_gen: RTL and testbench

Upstream raster timing stage for the TinyVGA demo top level. It produces pixel coordinates, sync pulses, the active-video flag and frame/line strobes consumed by the pattern and sprite logic.
- All outputs are registered and mutually aligned: every output describes the pixel currently addressed by hpos/vpos.
- Default timing is 640x480@60 with a 25.175 MHz pixel clock.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_axis_counter.sv | 79 +++++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared TinyVGA raster constants: default 640x480@60 timing, axis total
// helpers and the TinyVGA PMOD pin order used by the demo top level.
package vga_pkg;

    localparam int H_DISPLAY_DEF       = 640;
    localparam int H_FRONT_DEF         = 16;
    localparam int H_SYNC_DEF          = 96;
    localparam int H_BACK_DEF          = 48;
    localparam int V_DISPLAY_DEF       = 480;
    localparam int V_FRONT_DEF         = 10;
    localparam int V_SYNC_DEF          = 2;
    localparam int V_BACK_DEF          = 33;
    localparam int SYNC_ACTIVE_LOW_DEF = 1;
    localparam int CW_DEF              = 10;

    // Bit positions of each signal on the TinyVGA PMOD output byte.
    typedef enum logic [2:0] {
        PIN_R1    = 3'd0,
        PIN_G1    = 3'd1,
        PIN_B1    = 3'd2,
        PIN_VSYNC = 3'd3,
        PIN_R0    = 3'd4,
        PIN_G0    = 3'd5,
        PIN_B0    = 3'd6,
        PIN_HSYNC = 3'd7
    } tinyvga_pin_e;

    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int h_total(input int display, input int front,
                                   input int sync, input int back);
        return axis_total(display, front, sync, back);
    endfunction

    function automatic int v_total(input int display, input int front,
                                   input int sync, input int back);
        return axis_total(display, front, sync, back);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pattern/sprite consumers.
// master = timing generator (drives), slave = pixel pipeline (reads).
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic [CW-1:0] hpos;
    logic [CW-1:0] vpos;
    logic          hsync;
    logic          vsync;
    logic          display_on;
    logic          line_start;
    logic          frame_start;
    logic [15:0]   frame_count;

    modport master (
        output hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame_count
    );

    modport slave (
        input hpos, vpos, hsync, vsync, display_on,
              line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical). Holds the position counter and a
// registered sync pin level derived from the next count, so the sync pin is
// aligned with the count. Exposes next-count decodes so the top can register
// its combined flags with the same alignment, and a wrap flag that enables
// the following axis.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int DISPLAY    = H_DISPLAY_DEF,
    parameter int FRONT      = H_FRONT_DEF,
    parameter int SYNC       = H_SYNC_DEF,
    parameter int BACK       = H_BACK_DEF,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int CW         = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          sync,
    output logic          active_next,
    output logic          first_next,
    output logic          wrap
);

    localparam int            TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] DISP_LIMIT = CW'(DISPLAY);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(DISPLAY + FRONT);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(DISPLAY + FRONT + SYNC - 1);
    localparam logic          SYNC_IDLE  = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          sync_r;
    logic          sync_next_s;

    // Next position: wrap at the last pixel/line, hold when not stepping.
    always_comb begin
        count_next_s = count_r;
        if (step) begin
            if (count_r == LAST) begin
                count_next_s = {CW{1'b0}};
            end else begin
                count_next_s = count_r + CW'(1);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Sync pin level for the position being entered.
    always_comb begin
        sync_next_s = SYNC_IDLE;
        if ((count_next_s >= SYNC_FIRST) && (count_next_s <= SYNC_LAST)) begin
            sync_next_s = ~SYNC_IDLE;
        end else begin
            sync_next_s = SYNC_IDLE;
        end
    end

    // Position and sync registers; reset parks on the last position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= LAST;
            sync_r  <= SYNC_IDLE;
        end else begin
            count_r <= count_next_s;
            sync_r  <= sync_next_s;
        end
    end

    assign count       = count_r;
    assign sync        = sync_r;
    assign active_next = (count_next_s < DISP_LIMIT);
    assign first_next  = (count_next_s == {CW{1'b0}});
    assign wrap        = (count_r == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the TinyVGA demo. Produces pixel coordinates,
// sync pins, display enable, line/frame strobes and a frame counter, all
// registered and describing the pixel at hpos/vpos.
// Optional build macro VGA_TIMING_PIX_EN_EN adds a pix_en port; the raster
// then advances only on enabled edges (e.g. 50 MHz clock with div-2 enable).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY       = H_DISPLAY_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_DISPLAY       = V_DISPLAY_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BACK          = V_BACK_DEF,
    parameter int SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF,
    parameter int CW              = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef VGA_TIMING_PIX_EN_EN
    input  logic             pix_en,
`endif
    vga_timing_gen_if.master vga
);

    localparam bit SYNC_LOW = (SYNC_ACTIVE_LOW != 0);

    logic          adv_s;
    logic          v_step_s;
    logic          frame_wrap_s;
    logic [CW-1:0] h_count_s;
    logic [CW-1:0] v_count_s;
    logic          h_sync_s;
    logic          v_sync_s;
    logic          h_active_nx_s;
    logic          v_active_nx_s;
    logic          h_first_nx_s;
    logic          v_first_nx_s;
    logic          h_wrap_s;
    logic          v_wrap_s;

    logic          display_on_r;
    logic          line_start_r;
    logic          frame_start_r;
    logic [15:0]   frame_count_r;

`ifdef VGA_TIMING_PIX_EN_EN
    assign adv_s = pix_en;
`else
    assign adv_s = 1'b1;
`endif

    // Vertical axis steps once per line; the frame ends when both axes wrap.
    assign v_step_s     = adv_s & h_wrap_s;
    assign frame_wrap_s = v_step_s & v_wrap_s;

    vga_axis_counter #(
        .DISPLAY    (H_DISPLAY),
        .FRONT      (H_FRONT),
        .SYNC       (H_SYNC),
        .BACK       (H_BACK),
        .ACTIVE_LOW (SYNC_LOW),
        .CW         (CW)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (adv_s),
        .count       (h_count_s),
        .sync        (h_sync_s),
        .active_next (h_active_nx_s),
        .first_next  (h_first_nx_s),
        .wrap        (h_wrap_s)
    );

    vga_axis_counter #(
        .DISPLAY    (V_DISPLAY),
        .FRONT      (V_FRONT),
        .SYNC       (V_SYNC),
        .BACK       (V_BACK),
        .ACTIVE_LOW (SYNC_LOW),
        .CW         (CW)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (v_step_s),
        .count       (v_count_s),
        .sync        (v_sync_s),
        .active_next (v_active_nx_s),
        .first_next  (v_first_nx_s),
        .wrap        (v_wrap_s)
    );

    // Combined flags and frame counter, decoded from the next position so
    // they line up with the counters; holding the position holds the flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display_on_r  <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= 16'hFFFF;
        end else begin
            display_on_r  <= h_active_nx_s & v_active_nx_s;
            line_start_r  <= h_first_nx_s;
            frame_start_r <= h_first_nx_s & v_first_nx_s;
            if (frame_wrap_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign vga.hpos        = h_count_s;
    assign vga.vpos        = v_count_s;
    assign vga.hsync       = h_sync_s;
    assign vga.vsync       = v_sync_s;
    assign vga.display_on  = display_on_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
    assign vga.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster (32x20) so
// whole frames fit in a short run. A reference model pushes the expected
// pixel state into a scoreboard queue as each edge is driven; the entry is
// popped and compared once the DUT outputs settle after that edge.
module tb_vga_timing_gen;

    localparam int HD = 16, HF = 4, HS = 6, HB = 6;
    localparam int VD = 12, VF = 2, VS = 3, VB = 3;
    localparam int CW = 5;
    localparam int HT = HD + HF + HS + HB;  // 32 == 2^CW
    localparam int VT = VD + VF + VS + VB;  // 20
`ifdef VGA_TIMING_PIX_EN_EN
    localparam bit HAS_EN = 1'b1;
`else
    localparam bit HAS_EN = 1'b0;
`endif

    typedef struct {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          hs;
        logic          vs;
        logic          de;
        logic          ls;
        logic          fs;
        logic [15:0]   fc;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pix_en = 1'b1;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          m_h      = HT - 1;
    int          m_v      = VT - 1;
    logic [15:0] m_fc     = 16'hFFFF;
    exp_t        sb[$];

    vga_timing_gen_if #(.CW(CW)) vga ();

    vga_timing_gen #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_ACTIVE_LOW (1), .CW (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef VGA_TIMING_PIX_EN_EN
        .pix_en (pix_en),
`endif
        .vga    (vga)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        e.h  = m_h[CW-1:0];
        e.v  = m_v[CW-1:0];
        e.hs = !((m_h >= HD + HF) && (m_h <= HD + HF + HS - 1));
        e.vs = !((m_v >= VD + VF) && (m_v <= VD + VF + VS - 1));
        e.de = (m_h < HD) && (m_v < VD);
        e.ls = (m_h == 0);
        e.fs = (m_h == 0) && (m_v == 0);
        e.fc = m_fc;
        return e;
    endfunction

    // Drive one clock edge, update the model, and score the result.
    task automatic step(input logic r, input logic en);
        exp_t e;
        rst_n  = r;
        pix_en = en;
        if (!r) begin
            m_h  = HT - 1;
            m_v  = VT - 1;
            m_fc = 16'hFFFF;
        end else if (pix_en || !HAS_EN) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v  = 0;
                    m_fc = m_fc + 16'd1;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
        end
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cyc=%0d", cyc);
        end else begin
            e = sb.pop_front();
            if (vga.hpos !== e.h || vga.vpos !== e.v || vga.hsync !== e.hs ||
                vga.vsync !== e.vs || vga.display_on !== e.de ||
                vga.line_start !== e.ls || vga.frame_start !== e.fs ||
                vga.frame_count !== e.fc) begin
                failures++;
                $display("FAIL scoreboard cyc=%0d got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                         cyc, vga.hpos, vga.vpos, vga.hsync, vga.vsync,
                         vga.display_on, vga.line_start, vga.frame_start,
                         vga.frame_count, e.h, e.v, e.hs, e.vs, e.de, e.ls,
                         e.fs, e.fc);
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (vga.hpos !== 5'd31 || vga.vpos !== 5'd19 || vga.hsync !== 1'b1 ||
            vga.vsync !== 1'b1 || vga.display_on !== 1'b0 ||
            vga.line_start !== 1'b0 || vga.frame_start !== 1'b0 ||
            vga.frame_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_values got h=%0d v=%0d fc=%h", vga.hpos, vga.vpos, vga.frame_count);
        end
        step(1'b1, 1'b1);
        checks++;
        if (vga.hpos !== 5'd0 || vga.vpos !== 5'd0 || vga.display_on !== 1'b1 ||
            vga.frame_start !== 1'b1 || vga.line_start !== 1'b1 ||
            vga.frame_count !== 16'd0 || vga.hsync !== 1'b1 || vga.vsync !== 1'b1) begin
            failures++;
            $display("FAIL first_edge got h=%0d v=%0d fs=%b ls=%b fc=%h required h=0 v=0 fs=1 ls=1 fc=0",
                     vga.hpos, vga.vpos, vga.frame_start, vga.line_start, vga.frame_count);
        end
    endtask

    task automatic test_line();
        int hs_low = 0, de_low = 0, n_ls = 0, ls_prev = -1, bad = 0;
        for (int i = 0; i < 2 * HT; i++) begin
            step(1'b1, 1'b1);
            if (vga.hsync === 1'b0) hs_low++;
            if (vga.display_on === 1'b0) de_low++;
            if (vga.line_start === 1'b1) begin
                if (ls_prev >= 0 && cyc - ls_prev != HT) bad++;
                ls_prev = cyc;
                n_ls++;
            end
        end
        checks++;
        if (hs_low != 2 * HS) begin
            failures++;
            $display("FAIL hsync_width got=%0d required=%0d", hs_low, 2 * HS);
        end
        checks++;
        if (de_low != 2 * (HT - HD)) begin
            failures++;
            $display("FAIL display_blank got=%0d required=%0d", de_low, 2 * (HT - HD));
        end
        checks++;
        if (n_ls != 2 || bad != 0) begin
            failures++;
            $display("FAIL line_start_period got count=%0d bad=%0d required count=2 bad=0", n_ls, bad);
        end
    endtask

    task automatic test_frame();
        int vs_low = 0, n_fs = 0, fs_prev = -1, bad = 0, max_h = 0, max_v = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'b1, 1'b1);
            if (vga.vsync === 1'b0) vs_low++;
            if (int'(vga.hpos) > max_h) max_h = int'(vga.hpos);
            if (int'(vga.vpos) > max_v) max_v = int'(vga.vpos);
            if (vga.frame_start === 1'b1) begin
                if (fs_prev >= 0 && cyc - fs_prev != HT * VT) bad++;
                fs_prev = cyc;
                n_fs++;
            end
        end
        checks++;
        if (vs_low != 2 * VS * HT) begin
            failures++;
            $display("FAIL vsync_width got=%0d required=%0d", vs_low, 2 * VS * HT);
        end
        checks++;
        if (n_fs != 2 || bad != 0) begin
            failures++;
            $display("FAIL frame_start_period got count=%0d bad=%0d required count=2 bad=0", n_fs, bad);
        end
        checks++;
        if (max_h != HT - 1 || max_v != VT - 1) begin
            failures++;
            $display("FAIL counter_max got h=%0d v=%0d required h=%0d v=%0d", max_h, max_v, HT - 1, VT - 1);
        end
    endtask

    task automatic test_frame_count();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (vga.frame_count !== 16'd0) begin
            failures++;
            $display("FAIL frame_count_wrap got=%h required=0000", vga.frame_count);
        end
        for (int k = 1; k <= 2; k++) begin
            bit found = 1'b0;
            for (int i = 0; i < HT * VT + 4 && !found; i++) begin
                step(1'b1, 1'b1);
                if (vga.frame_start === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found || vga.frame_count !== 16'(k)) begin
                failures++;
                $display("FAIL frame_count found=%0d got=%0d required=%0d", found, vga.frame_count, k);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        for (int i = 0; i < HT * VT + 4 && !found; i++) begin
            step(1'b1, 1'b1);
            if (vga.hpos === 5'd22 && vga.vpos === 5'd15) found = 1'b1;
        end
        checks++;
        if (!found || vga.hsync !== 1'b0 || vga.vsync !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_setup found=%0d hs=%b vs=%b required found=1 hs=0 vs=0",
                     found, vga.hsync, vga.vsync);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (vga.hpos !== 5'd31 || vga.vpos !== 5'd19 || vga.hsync !== 1'b1 ||
                vga.vsync !== 1'b1 || vga.display_on !== 1'b0 ||
                vga.frame_start !== 1'b0 || vga.frame_count !== 16'hFFFF) begin
                failures++;
                $display("FAIL mid_reset_hold got h=%0d v=%0d hs=%b vs=%b fc=%h required h=31 v=19 hs=1 vs=1 fc=ffff",
                         vga.hpos, vga.vpos, vga.hsync, vga.vsync, vga.frame_count);
            end
        end
        step(1'b1, 1'b1);
        checks++;
        if (vga.hpos !== 5'd0 || vga.vpos !== 5'd0 || vga.frame_start !== 1'b1 ||
            vga.frame_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset_release got h=%0d v=%0d fs=%b fc=%h required h=0 v=0 fs=1 fc=0",
                     vga.hpos, vga.vpos, vga.frame_start, vga.frame_count);
        end
    endtask

`ifdef VGA_TIMING_PIX_EN_EN
    task automatic test_pix_en();
        int hs_low = 0, fs_clk = 0, bad_hold = 0;
        logic [CW-1:0] last_h = '0;
        step(1'b0, 1'b1);
        for (int i = 0; i < 4 * HT; i++) begin
            step(1'b1, (i % 2) == 0);
            if (vga.hsync === 1'b0) hs_low++;
            if (vga.frame_start === 1'b1) fs_clk++;
            if ((i % 2) == 1 && vga.hpos !== last_h) bad_hold++;
            last_h = vga.hpos;
        end
        checks++;
        if (hs_low != 2 * 2 * HS) begin
            failures++;
            $display("FAIL pix_en_hsync got=%0d required=%0d", hs_low, 4 * HS);
        end
        checks++;
        if (fs_clk != 2) begin
            failures++;
            $display("FAIL pix_en_frame_start got=%0d required=2", fs_clk);
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL pix_en_hold got=%0d required=0", bad_hold);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_frame_count();
        test_mid_reset();
`ifdef VGA_TIMING_PIX_EN_EN
        test_pix_en();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
